// File: rtl/decimal_pkg.sv
// Shared types and constants for the decimal keypad entry path.
package decimal_pkg;

  // Entry state, derived from how many digits are held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int BCD_MAX   = 9;
  localparam int DEC_RADIX = 10;

  // Bit positions of the three keys in the packed key/edge vectors.
  localparam int KEY_DIG = 0;
  localparam int KEY_DEL = 1;
  localparam int KEY_ENT = 2;
  localparam int NUM_KEYS = 3;

endpackage

// File: rtl/decimal_entry_key_edge.sv
// Rising-edge detector for one synchronized key level.
module key_edge (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic pulse
);

  logic prev;

  // prev resets high so a key already held through reset never fires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev <= 1'b1;
    else         prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/decimal_entry.sv
// Keypad entry: accumulates up to MAX_DIGITS BCD digits into a binary value
// with delete, enter and range checking.
module decimal_entry
  import decimal_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int MAX_VALUE  = 127,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       digit_in,
  input  logic             digit_key,
  input  logic             del_key,
  input  logic             enter_key,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       digit_count,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err
);

  localparam int NW = WIDTH + 4;

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] edges;
  state_t              state;
  logic [NW-1:0]       acc_ext;
  logic [NW-1:0]       next_val;
  logic [WIDTH-1:0]    acc_div;
  logic [1:0]          count_inc;
  logic                digit_bad;

  assign keys[KEY_DIG] = digit_key;
  assign keys[KEY_DEL] = del_key;
  assign keys[KEY_ENT] = enter_key;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_edge u_edge (
      .clk   (clk),
      .resetn(resetn),
      .level (keys[k]),
      .pulse (edges[k])
    );
  end

  // x10 as shift-add in the widened domain so overflow past MAX_VALUE is visible.
  assign acc_ext   = {4'b0, acc};
  assign next_val  = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit_in};
  assign acc_div   = acc / WIDTH'(DEC_RADIX);
  assign count_inc = digit_count + 2'd1;
  assign digit_bad = (digit_in > 4'(BCD_MAX)) || (state == FULL) ||
                     (next_val > NW'(MAX_VALUE));

  // Entry FSM: one action per cycle, enter > del > digit; strobes self-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= EMPTY;
      acc          <= '0;
      digit_count  <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      if (edges[KEY_ENT]) begin
        if (state == EMPTY) begin
          err <= 1'b1;
        end else begin
          result       <= acc;
          result_valid <= 1'b1;
          acc          <= '0;
          digit_count  <= '0;
          state        <= EMPTY;
        end
      end else if (edges[KEY_DEL]) begin
        if (state == EMPTY) begin
          err <= 1'b1;
        end else begin
          acc         <= acc_div;
          digit_count <= digit_count - 2'd1;
          state       <= (digit_count == 2'd1) ? EMPTY : ENTRY;
        end
      end else if (edges[KEY_DIG]) begin
        if (digit_bad) begin
          err <= 1'b1;
        end else begin
          acc         <= next_val[WIDTH-1:0];
          digit_count <= count_inc;
          state       <= (count_inc == 2'(MAX_DIGITS)) ? FULL : ENTRY;
        end
      end
    end
  end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Sequential decimal keypad entry: accumulates up to three BCD digit key presses into a 7-bit binary value (0–127), with delete, enter and bounds checking. It is the input-side counterpart of the binary-to-decimal display path. Its live accumulator drives the three-digit decimal display while the user types. On enter it hands the committed binary value to the game logic as a one-cycle strobe.

## Interface
- WIDTH, 7: bit width of the accumulated and committed value.
- MAX_VALUE, 127: largest accepted value; must be ≤ 2^WIDTH−1.
- MAX_DIGITS, 3: maximum digits accepted.

- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- digit_in  in  4  BCD digit to append; sampled in the cycle a digit_key rising edge is detected.
- digit_key  in  1  active-high level, already synchronized; each rising edge appends digit_in.
- del_key  in  1  active-high level; each rising edge removes the last digit.
- enter_key  in  1  active-high level; each rising edge commits the value.
- acc  out  WIDTH  live accumulated value, intended for the decimal display.
- digit_count  out  2  number of digits currently entered (0..MAX_DIGITS).
- result  out  WIDTH  last committed value; holds until the next commit.
- result_valid  out  1  one-cycle strobe when result updates.
- err  out  1  one-cycle strobe on any rejected action.

## Operation
- Edge detection: one previous-level register per key. Edge = level & ~prev. The prev registers reset to 1, so a key held through reset does not fire.
- Priority when several edges occur in the same cycle: enter > del > digit. Lower-priority edges in that cycle are dropped silently, with no err.
- FSM states, derived from digit_count:
  - EMPTY: count 0.
  - ENTRY: 1 ≤ count < MAX_DIGITS.
  - FULL: count = MAX_DIGITS.
- Digit edge:
  - Reject with err if digit_in > 9, or if the state is FULL.
  - Otherwise compute next = acc*10 + digit_in in WIDTH+4 bits.
  - If next > MAX_VALUE: reject with err; acc and count are unchanged.
  - Otherwise acc ← next and count ← count+1.
  - Leading zeros are accepted and counted ("007" → 7, count 3).
- Del edge:
  - In EMPTY: reject with err.
  - Otherwise acc ← acc/10 (integer division) and count ← count−1.
- Enter edge:
  - In EMPTY: reject with err.
  - Otherwise result ← acc, result_valid ← 1, acc ← 0, count ← 0, state → EMPTY.
- err and result_valid are never both asserted in the same cycle.

## Timing
- Reset values: acc=0, digit_count=0, result=0, result_valid=0, err=0, state EMPTY, all prev registers=1.
- Reset is asynchronous. Asserting it mid-entry clears everything immediately, and no result_valid is issued.
- Latency: a key edge detected in cycle N (level high, prev low) updates acc, digit_count, result, result_valid and err at the clock edge ending cycle N. They are visible in cycle N+1.
- result_valid and err last exactly one cycle each.
- A key held high produces exactly one action. It must return low for at least one cycle before it can fire again.
- Back-to-back edges on alternating cycles are all processed, with no dead cycles.

## Structure
- Shared package decimal_pkg:
  - State enum: EMPTY, ENTRY, FULL.
  - Constant BCD_MAX = 9.
  - Constant DEC_RADIX = 10.
- Sub-module key_edge: one register per instance, prev resets to 1, outputs a rising-edge pulse. Instantiate it three times.
- The ×10 operation is implemented as (acc<<3)+(acc<<1). The ÷10 operation is a combinational constant divide. Neither needs a separate module.

## Test plan
- Reset with digit_key held high, then release and press digits 1,2,7 then enter → no spurious append after reset; acc goes 1, 12, 127; result=127 with a one-cycle result_valid; acc=0 and count=0 afterwards.
- Press 1,2 then 8 → the 8 is rejected (128 > 127): err pulses, acc stays 12, count stays 2.
- Press 4,5,6 then del twice → acc 4,45,456 is invalid. Instead press 4,5, then 6: expect err (456 > 127). Then del → acc=4, count=1. Then del → acc=0, count=0. A third del → err.
- digit_in=4'hA with a digit edge → err, acc unchanged. Press 0,0,7 → acc=7, count=3, state FULL. A further digit press → err.
- Assert enter, del and digit edges in the same cycle with acc=12 → commit only: result=12, result_valid pulses, no err. Enter pressed in EMPTY → err and no result_valid.
- Assert resetn low mid-entry with acc=9, count=1 → all outputs take their reset values asynchronously. result keeps its reset value 0.
